// File: rtl/cache_responder_pkg.sv
// Shared types for the cache responder: opcodes, FSM states and default geometry.
package cache_responder_pkg;

    // Opcodes carried on the cache interface operation lines.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INVAL = 2'b10,
        OP_NOP   = 2'b11
    } inst_t;

    // Responder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_RESPOND   = 3'd4
    } resp_state_t;

    // Default geometry.
    localparam int DEF_WORD_W = 8;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINES  = 16;

    // True when the opcode returns a data word to the master.
    function automatic logic op_returns_data(input inst_t op);
        return (op == OP_READ);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the direct-mapped cache: one combinational read port,
// one write port, valid/dirty bits cleared on reset. Packed line layout is
// {valid, dirty, tag, data}, MSB first.
module cache_line_array #(
    parameter int WORD_W = 8,
    parameter int TAG_W  = 28,
    parameter int LINES  = 16,
    parameter int IDX_W  = $clog2(LINES),
    parameter int LINE_W = 2 + TAG_W + WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [LINES-1:0]  dirty_q;
    logic [LINES-1:0]  dirty_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];

    // Next-state of the valid/dirty bit vectors from the write port.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_line[LINE_W-1];
            dirty_d[wr_idx] = wr_line[LINE_W-2];
        end else begin
            valid_d = valid_q;
            dirty_d = dirty_q;
        end
    end

    // Valid/dirty bits: cleared asynchronously so a reset forgets every line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data payload; meaningless while the line is invalid, so unreset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_line[WORD_W+TAG_W-1:WORD_W];
            data_q[wr_idx] <= wr_line[WORD_W-1:0];
        end
    end

    // Combinational read port.
    always_comb begin
        rd_line = {valid_q[rd_idx], dirty_q[rd_idx], tag_q[rd_idx], data_q[rd_idx]};
    end

endmodule

// File: rtl/cache_responder.sv
// Slave-side four-phase responder implementing a direct-mapped, write-back,
// write-allocate cache with single-word lines in front of a req/ack memory.
module cache_responder
    import cache_responder_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINES  = DEF_LINES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        operation,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_oe,
    input  logic              request,
    output logic              valid,
    output logic              evict,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int LINE_W = 2 + TAG_W + WORD_W;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] data;
    } line_t;

    resp_state_t       state_q, state_d;
    inst_t             op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              evict_flag_q, evict_flag_d;
    logic              valid_q, valid_d;
    logic              evict_q, evict_d;
    logic              data_oe_q, data_oe_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    line_t             rd_line_s;
    line_t             wr_line_s;
    logic              wr_en_s;
    logic              hit_s;
    logic              displaced_s;
    logic              need_wb_s;
    logic              upd_en_s;
    line_t             upd_line_s;

    // Split the latched address into line index and tag.
    always_comb begin
        idx_s = addr_q[IDX_W-1:0];
        tag_s = addr_q[ADDR_W-1:IDX_W];
    end

    cache_line_array #(
        .WORD_W (WORD_W),
        .TAG_W  (TAG_W),
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .LINE_W (LINE_W)
    ) u_lines (
        .clock   (clock),
        .reset   (reset),
        .rd_idx  (idx_s),
        .rd_line (rd_line_s),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_s),
        .wr_line (wr_line_s)
    );

    // Hit/miss classification and whether the resident line gets displaced.
    always_comb begin
        hit_s = rd_line_s.valid && (rd_line_s.tag == tag_s);
        case (op_q)
            OP_READ, OP_WRITE: displaced_s = rd_line_s.valid && !hit_s;
            OP_INVAL:          displaced_s = rd_line_s.valid;
            default:           displaced_s = 1'b0;
        endcase
        need_wb_s = displaced_s && rd_line_s.dirty;
    end

    // Final line update once any writeback is done: writes install dirty data,
    // invalidates clear the line, reads and nops leave storage alone here.
    always_comb begin
        upd_line_s = rd_line_s;
        case (op_q)
            OP_WRITE: begin
                upd_en_s         = 1'b1;
                upd_line_s.valid = 1'b1;
                upd_line_s.dirty = 1'b1;
                upd_line_s.tag   = tag_s;
                upd_line_s.data  = wdata_q;
            end
            OP_INVAL: begin
                upd_en_s         = 1'b1;
                upd_line_s.valid = 1'b0;
                upd_line_s.dirty = 1'b0;
            end
            default: begin
                upd_en_s = 1'b0;
            end
        endcase
    end

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        evict_flag_d = evict_flag_q;
        valid_d      = valid_q;
        evict_d      = evict_q;
        data_oe_d    = data_oe_q;
        data_out_d   = data_out_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wr_en_s      = 1'b0;
        wr_line_s    = '0;

        case (state_q)
            ST_IDLE: begin
                valid_d   = 1'b0;
                evict_d   = 1'b0;
                data_oe_d = 1'b0;
                if (request) begin
                    op_d    = inst_t'(operation);
                    addr_d  = addr;
                    wdata_d = data_in;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOOKUP: begin
                evict_flag_d = displaced_s;
                if (need_wb_s) begin
                    state_d     = ST_WRITEBACK;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {rd_line_s.tag, idx_s};
                    mem_wdata_d = rd_line_s.data;
                end else if ((op_q == OP_READ) && !hit_s) begin
                    state_d    = ST_FILL;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else begin
                    // No memory traffic: commit now and answer.
                    wr_en_s   = upd_en_s;
                    wr_line_s = upd_line_s;
                    if (op_q == OP_READ) begin
                        data_out_d = rd_line_s.data;
                    end else begin
                        data_out_d = data_out_q;
                    end
                    state_d   = ST_RESPOND;
                    valid_d   = 1'b1;
                    evict_d   = displaced_s;
                    data_oe_d = op_returns_data(op_q);
                end
            end

            ST_WRITEBACK: begin
                if (mem_ack) begin
                    if (op_q == OP_READ) begin
                        // Request stays up; it becomes the fill.
                        state_d    = ST_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                    end else begin
                        wr_en_s   = upd_en_s;
                        wr_line_s = upd_line_s;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = ST_RESPOND;
                        valid_d   = 1'b1;
                        evict_d   = evict_flag_q;
                        data_oe_d = op_returns_data(op_q);
                    end
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end

            ST_FILL: begin
                if (mem_ack) begin
                    wr_en_s         = 1'b1;
                    wr_line_s.valid = 1'b1;
                    wr_line_s.dirty = 1'b0;
                    wr_line_s.tag   = tag_s;
                    wr_line_s.data  = mem_rdata;
                    data_out_d      = mem_rdata;
                    mem_req_d       = 1'b0;
                    mem_we_d        = 1'b0;
                    state_d         = ST_RESPOND;
                    valid_d         = 1'b1;
                    evict_d         = evict_flag_q;
                    data_oe_d       = op_returns_data(op_q);
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_RESPOND: begin
                if (!request) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    evict_d   = 1'b0;
                    data_oe_d = 1'b0;
                end else begin
                    state_d = ST_RESPOND;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                valid_d   = 1'b0;
                evict_d   = 1'b0;
                data_oe_d = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // FSM state, latched request and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            addr_q       <= '0;
            wdata_q      <= '0;
            evict_flag_q <= 1'b0;
            valid_q      <= 1'b0;
            evict_q      <= 1'b0;
            data_oe_q    <= 1'b0;
            data_out_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            evict_flag_q <= evict_flag_d;
            valid_q      <= valid_d;
            evict_q      <= evict_d;
            data_oe_q    <= data_oe_d;
            data_out_q   <= data_out_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Output wiring from the registers.
    always_comb begin
        valid     = valid_q;
        evict     = evict_q;
        data_oe   = data_oe_q;
        data_out  = data_out_q;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_cache_responder.sv
// Bench for cache_responder: a line-level cache model predicts responses and
// memory transactions; monitors compare them as the DUT produces them.
module tb_cache_responder;
    import cache_responder_pkg::*;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 32;
    localparam int LINES  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        operation = 2'b11;
    logic [ADDR_W-1:0] addr = '0;
    logic [WORD_W-1:0] data_in = '0;
    logic [WORD_W-1:0] data_out;
    logic              data_oe;
    logic              request = 1'b0;
    logic              valid;
    logic              evict;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    cache_responder #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINES(LINES)) dut (
        .clock(clock), .reset(reset), .operation(operation), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .request(request), .valid(valid), .evict(evict), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int n_mem_txn = 0;
    int mem_wait_cfg = 0;
    bit stray_en = 1'b0;

    typedef struct packed {logic [1:0] op; logic [7:0] data; logic oe; logic ev;} resp_t;
    typedef struct packed {logic we; logic [31:0] addr; logic [7:0] wdata;} mtxn_t;
    resp_t exp_q[$];
    mtxn_t mexp_q[$];

    // Reference state: cache lines and backing memory.
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [27:0] m_tag   [LINES];
    logic [7:0]  m_data  [LINES];
    logic [7:0]  bmem [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bmem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    // Apply one operation to the model and queue what the DUT should do.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [7:0] d);
        int idx = int'(a[3:0]);
        logic [27:0] tg = a[31:4];
        bit hit = m_valid[idx] && (m_tag[idx] == tg);
        resp_t r;
        r = '{op: op, data: 8'h00, oe: 1'b0, ev: 1'b0};
        if (op == 2'b11) begin
            exp_q.push_back(r);
            return;
        end
        if (op == 2'b00 && hit) begin
            r.data = m_data[idx];
            r.oe = 1'b1;
            exp_q.push_back(r);
            return;
        end
        if (op == 2'b01 && hit) begin
            m_data[idx] = d;
            m_dirty[idx] = 1'b1;
            exp_q.push_back(r);
            return;
        end
        // Miss (or invalidate): the resident valid line leaves the cache.
        r.ev = m_valid[idx];
        if (m_valid[idx] && m_dirty[idx]) begin
            mexp_q.push_back('{we: 1'b1, addr: {m_tag[idx], 4'(idx)}, wdata: m_data[idx]});
            bmem[{m_tag[idx], 4'(idx)}] = m_data[idx];
        end
        case (op)
            2'b00: begin
                mexp_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
                r.data = bmem_rd(a);
                r.oe = 1'b1;
                m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg; m_data[idx] = r.data;
            end
            2'b01: begin
                m_valid[idx] = 1'b1; m_dirty[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = d;
            end
            default: begin
                m_valid[idx] = 1'b0; m_dirty[idx] = 1'b0;
            end
        endcase
        exp_q.push_back(r);
    endtask

    // Backing memory: ack after a wait, check each transaction, stray acks when idle.
    int mcnt = 0;
    always @(negedge clock) begin
        mtxn_t e;
        if (!reset) begin
            mem_ack = 1'b0;
            mcnt = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (mcnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = bmem_rd(mem_addr);
                    n_mem_txn++;
                    if (mexp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL mem_unexpected: got txn we=%0d addr=0x%0h, expected none", mem_we, mem_addr);
                    end else begin
                        e = mexp_q.pop_front();
                        check("mem_we", 32'(mem_we), 32'(e.we));
                        check("mem_addr", mem_addr, e.addr);
                        if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    end
                    mcnt = (mem_wait_cfg >= 0) ? mem_wait_cfg : int'($urandom_range(0, 3));
                end else begin
                    mcnt--;
                end
            end else begin
                mcnt = (mem_wait_cfg >= 0) ? mem_wait_cfg : int'($urandom_range(0, 3));
                if (stray_en && $urandom_range(0, 7) == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Response monitor: on each rising valid compare against the scoreboard.
    logic valid_prev = 1'b0;
    always @(posedge clock) begin
        resp_t e;
        #1;
        if (!reset) begin
            valid_prev = 1'b0;
        end else begin
            if (valid && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL resp_unexpected: got valid=1, expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_evict", 32'(evict), 32'(e.ev));
                    check("resp_data_oe", 32'(data_oe), 32'(e.oe));
                    if (e.op == OP_READ) check("resp_data_out", 32'(data_out), 32'(e.data));
                end
            end
            valid_prev = valid;
        end
    end

    // Run one transaction; lat counts the sampling edge as 1, width is valid-high cycles.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [7:0] d,
                         input bit drop_early, output int lat, output int width);
        int guard;
        @(negedge clock);
        operation = op; addr = a; data_in = d; request = 1'b1;
        model_op(op, a, d);
        @(posedge clock);
        lat = 1; width = 0;
        #1;
        operation = 2'($urandom); addr = $urandom; data_in = 8'($urandom);
        if (drop_early) begin
            @(negedge clock);
            request = 1'b0;
        end
        guard = 0;
        while (!valid && guard < 100) begin
            @(posedge clock); #1;
            lat++; guard++;
        end
        if (!valid) begin
            check("valid_timeout", 32'(valid), 32'd1);
            request = 1'b0;
            return;
        end
        width = 1;
        if (!drop_early) begin
            @(negedge clock);
            request = 1'b0;
        end
        guard = 0;
        forever begin
            @(posedge clock); #1;
            if (!valid || guard > 50) break;
            width++; guard++;
        end
        if (valid) check("valid_stuck", 32'(valid), 32'd0);
    endtask

    initial begin
        int lat, width, t0;
        #200_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, width, t0, guard;
        logic [27:0] tg;
        logic [3:0] ix;
        // Reset values.
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_evict", 32'(evict), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Read miss on a clean cache, memory waits 3 cycles.
        bmem[32'h13] = 8'hA5;
        mem_wait_cfg = 3;
        t0 = n_mem_txn;
        do_op(2'b00, 32'h13, 8'h00, 1'b0, lat, width);
        check("miss_lat", lat, 32'd6);
        check("miss_txns", n_mem_txn - t0, 32'd1);

        // Read hit.
        t0 = n_mem_txn;
        do_op(2'b00, 32'h13, 8'h00, 1'b0, lat, width);
        check("hit_lat", lat, 32'd2);
        check("hit_txns", n_mem_txn - t0, 32'd0);

        // Write hit, then a conflicting read forces writeback plus fill.
        do_op(2'b01, 32'h13, 8'h3C, 1'b0, lat, width);
        check("whit_lat", lat, 32'd2);
        mem_wait_cfg = 1;
        t0 = n_mem_txn;
        do_op(2'b00, 32'h23, 8'h00, 1'b0, lat, width);
        check("conflict_lat", lat, 32'd6);
        check("conflict_txns", n_mem_txn - t0, 32'd2);

        // Invalidate a dirty line, then invalidate the now-invalid line.
        do_op(2'b01, 32'h23, 8'h77, 1'b0, lat, width);
        t0 = n_mem_txn;
        do_op(2'b10, 32'h23, 8'h00, 1'b0, lat, width);
        check("inval_dirty_lat", lat, 32'd4);
        check("inval_dirty_txns", n_mem_txn - t0, 32'd1);
        t0 = n_mem_txn;
        do_op(2'b10, 32'h23, 8'h00, 1'b0, lat, width);
        check("inval_empty_lat", lat, 32'd2);
        check("inval_empty_txns", n_mem_txn - t0, 32'd0);

        // Request dropped early during a miss.
        mem_wait_cfg = 2;
        do_op(2'b00, 32'h45, 8'h00, 1'b1, lat, width);
        check("drop_lat", lat, 32'd5);
        check("drop_width", width, 32'd1);

        // Reset asynchronously while a fill is outstanding.
        mem_wait_cfg = 10;
        @(negedge clock);
        operation = 2'b00; addr = 32'h99; request = 1'b1;
        model_op(2'b00, 32'h99, 8'h00);
        guard = 0;
        do begin
            @(posedge clock); #1; guard++;
        end while (!(mem_req && !mem_we) && guard < 20);
        check("fill_seen", 32'(mem_req && !mem_we), 32'd1);
        #2;
        reset = 1'b0; request = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        exp_q.delete();
        mexp_q.delete();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        mem_wait_cfg = 0;
        t0 = n_mem_txn;
        do_op(2'b00, 32'h99, 8'h00, 1'b0, lat, width);
        check("post_rst_lat", lat, 32'd3);
        check("post_rst_txns", n_mem_txn - t0, 32'd1);

        // Randomized traffic over a few tags per index.
        mem_wait_cfg = -1;
        stray_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            tg = 28'($urandom_range(0, 3));
            ix = 4'($urandom_range(0, 15));
            do_op(2'($urandom), {tg, ix}, 8'($urandom), ($urandom_range(0, 7) == 0), lat, width);
        end
        stray_en = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("resp_queue_empty", exp_q.size(), 32'd0);
        check("mem_queue_empty", mexp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
